ring_decoder_monitor: RTL

- Receive-side companion to the team's one-hot ring counters.
- Samples a WIDTH-bit one-hot ring vector, decodes it to a binary phase index, and checks that successive samples follow the right-rotate sequence 1000 -> 0100 -> 0010 -> 0001 -> 1000.
- Acquires lock after LOCK_CNT consistent samples, then flags, counts and recovers from sequence errors.
- Sits between a ring counter and any logic that needs a trusted phase index.

---
 rtl/ring_decoder_monitor.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ring_decoder_monitor.sv
// Decodes a one-hot ring vector to a phase index and watches that successive
// samples follow the right-rotate sequence, with lock acquisition and error counting.
module ring_decoder_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     clr_err,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     idx_valid,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [ERR_W-1:0]         err_cnt,
    output logic                     wrap_pulse,
    output logic [1:0]               dbg_state_o
);

    localparam int IDX_W  = $clog2(WIDTH);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    // Handshake: ring_in is consumed on every rising edge where en=1; there is
    // no backpressure, and outputs describe the sample taken on the previous edge.

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    exp_q, exp_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                idx_valid_q, idx_valid_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic                wrap_q, wrap_d;

    logic                legal;
    logic                match;
    logic [IDX_W-1:0]    dec_idx;
    logic [WIDTH-1:0]    rot;
    logic                err_ev;
    logic                wrap_ev;

    // Sample classification and decode
    always_comb begin
        dec_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                dec_idx = IDX_W'(WIDTH - 1 - i);
            end
        end
        legal = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
        match = (ring_in == exp_q);
        rot   = {ring_in[0], ring_in[WIDTH-1:1]};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            exp_q       <= '0;
            good_q      <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            good_q      <= good_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            wrap_q      <= wrap_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        good_d  = good_q;
        err_ev  = 1'b0;
        wrap_ev = 1'b0;
        if (en) begin
            unique case (state_q)
                ST_UNLOCKED: begin
                    if (legal) begin
                        state_d = ST_ACQUIRE;
                        good_d  = GOOD_W'(1);
                        exp_d   = rot;
                    end
                end
                ST_ACQUIRE: begin
                    if (match) begin
                        good_d = good_q + GOOD_W'(1);
                        exp_d  = rot;
                        if (good_d == GOOD_W'(LOCK_CNT)) begin
                            state_d = ST_LOCKED;
                        end
                    end else if (legal) begin
                        good_d = GOOD_W'(1);
                        exp_d  = rot;
                    end else begin
                        state_d = ST_UNLOCKED;
                        good_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        exp_d   = rot;
                        wrap_ev = ring_in[WIDTH-1];
                    end else begin
                        // Any deviation while locked is an error; a legal
                        // sample still seeds a fresh acquisition attempt.
                        err_ev = 1'b1;
                        if (legal) begin
                            state_d = ST_ACQUIRE;
                            good_d  = GOOD_W'(1);
                            exp_d   = rot;
                        end else begin
                            state_d = ST_UNLOCKED;
                            good_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                    good_d  = '0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        idx_valid_d = en && legal;
        idx_d       = idx_valid_d ? dec_idx : idx_q;
        locked_d    = (state_d == ST_LOCKED);
        err_pulse_d = err_ev;
        wrap_d      = wrap_ev;
        err_cnt_d   = err_cnt_q;
        // A clear that lands on an error still records that error.
        if (clr_err) begin
            err_cnt_d = err_ev ? ERR_W'(1) : '0;
        end else if (err_ev && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    assign idx         = idx_q;
    assign idx_valid   = idx_valid_q;
    assign locked      = locked_q;
    assign err_pulse   = err_pulse_q;
    assign err_cnt     = err_cnt_q;
    assign wrap_pulse  = wrap_q;
    assign dbg_state_o = state_q;

endmodule
